// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM output stage:
//     - default widths for the counter/compare path and the dead-time counter
//     - encodings of the `functions` alignment-mode field
//     - state encoding of the complementary-output dead-time FSM
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;

  typedef enum logic [1:0] {
    FUNC_LEFT  = 2'b00,
    FUNC_RIGHT = 2'b01,
    FUNC_RANGE = 2'b10,
    FUNC_RSVD  = 2'b11
  } func_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_DT_LO = 3'd2,
    ST_LO    = 3'd3,
    ST_DT_HI = 3'd4
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
//   Turns the combinational raw PWM level into a complementary output pair
//   with a programmable dead band on every transition. Outputs decode only
//   from the state register, so they are glitch-free and lag `raw` by 1 clk.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   raw         - raw PWM level for this cycle (already 0 when disabled)
//   pwm_en      - output enable; 0 parks the FSM in IDLE (outputs 00)
//   dead_time   - dead-band length in clk cycles, sampled at band entry
//   pwm_out     - main output
//   pwm_out_n   - complementary output
// -----------------------------------------------------------------------------
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            raw,
  input  logic            pwm_en,
  input  logic [DT_W-1:0] dead_time,
  output logic            pwm_out,
  output logic            pwm_out_n
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] dt_cnt;
  logic            dt_load;
  logic            in_band;

  assign in_band = (state_q == ST_DT_LO) || (state_q == ST_DT_HI);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // dt_cnt is loaded with dead_time on band entry and then counts down; the
  // band ends on the clk where it would reach 0, giving exactly dead_time
  // cycles of 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_cnt <= '0;
    end else if (dt_load) begin
      dt_cnt <= dead_time;
    end else if (in_band && (dt_cnt != '0)) begin
      dt_cnt <= dt_cnt - DT_W'(1);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    dt_load = 1'b0;
    if (!pwm_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = raw ? ST_HI : ST_LO;
        ST_HI: begin
          if (!raw) begin
            if (dead_time == '0) begin
              state_d = ST_LO;
            end else begin
              state_d = ST_DT_LO;
              dt_load = 1'b1;
            end
          end
        end
        ST_DT_LO: begin
          // raw back high inside the band: return to HI without a pulse.
          if (raw)                       state_d = ST_HI;
          else if (dt_cnt <= DT_W'(1))   state_d = ST_LO;
        end
        ST_LO: begin
          if (raw) begin
            if (dead_time == '0) begin
              state_d = ST_HI;
            end else begin
              state_d = ST_DT_HI;
              dt_load = 1'b1;
            end
          end
        end
        ST_DT_HI: begin
          if (!raw)                      state_d = ST_LO;
          else if (dt_cnt <= DT_W'(1))   state_d = ST_HI;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pwm_out   = 1'b0;
    pwm_out_n = 1'b0;
    case (state_q)
      ST_HI:   pwm_out   = 1'b1;
      ST_LO:   pwm_out_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
//   PWM output stage. Compares the live counter value against shadowed
//   compare thresholds in one of four alignment modes and produces a
//   registered PWM waveform plus a complementary output.
//
//   Build option: define PWM_DEADTIME_EN to compile in the dead-time FSM
//   (pwm_deadtime); otherwise pwm_out_n is simply the enabled complement.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   pwm_en       - output enable
//   functions    - alignment mode (left / right / range / reserved)
//   compare1/2   - compare thresholds (compare2 used in range mode only)
//   dead_time    - dead-band length in clk cycles (dead-time build only)
//   counter_val  - live count from the period counter
//   pwm_out      - main PWM output
//   pwm_out_n    - complementary PWM output
// -----------------------------------------------------------------------------
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_en,
  input  logic [1:0]       functions,
  input  logic [CNT_W-1:0] compare1,
  input  logic [CNT_W-1:0] compare2,
  input  logic [DT_W-1:0]  dead_time,
  input  logic [CNT_W-1:0] counter_val,
  output logic             pwm_out,
  output logic             pwm_out_n
);

  logic [CNT_W-1:0] prev_val;
  logic [CNT_W-1:0] sh_cmp1, sh_cmp2;
  func_e            sh_func;

  logic             cycle_start;
  logic             sh_load;
  logic [CNT_W-1:0] cmp1_eff, cmp2_eff;
  func_e            func_eff;
  logic             raw;

  // Edge-detect the wrap to zero: a prescaled counter holds 0 for several
  // clks, and a zero period never leaves 0, so only the transition counts.
  assign cycle_start = (counter_val == '0) && (prev_val != '0);
  assign sh_load     = !pwm_en || cycle_start;

  // On the loading cycle compare against the incoming values so the new
  // period starts with its own configuration rather than the stale one.
  assign cmp1_eff = sh_load ? compare1 : sh_cmp1;
  assign cmp2_eff = sh_load ? compare2 : sh_cmp2;
  assign func_eff = sh_load ? func_e'(functions) : sh_func;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_val <= '0;
      sh_cmp1  <= '0;
      sh_cmp2  <= '0;
      sh_func  <= FUNC_LEFT;
    end else begin
      prev_val <= counter_val;
      if (sh_load) begin
        sh_cmp1 <= compare1;
        sh_cmp2 <= compare2;
        sh_func <= func_e'(functions);
      end
    end
  end

  always_comb begin
    raw = 1'b0;
    if (pwm_en) begin
      case (func_eff)
        FUNC_LEFT:  raw = counter_val < cmp1_eff;
        FUNC_RIGHT: raw = counter_val >= cmp1_eff;
        FUNC_RANGE: raw = (counter_val >= cmp1_eff) && (counter_val < cmp2_eff);
        default:    raw = 1'b0;
      endcase
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DT_W (DT_W)
  ) u_deadtime (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (raw),
    .pwm_en    (pwm_en),
    .dead_time (dead_time),
    .pwm_out   (pwm_out),
    .pwm_out_n (pwm_out_n)
  );
`else
  // dead_time has no function in this build.
  logic unused_dead_time;
  assign unused_dead_time = ^dead_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      pwm_out   <= raw;
      pwm_out_n <= pwm_en && !raw;
    end
  end
`endif

endmodule
